// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and RX FIFO.
package uart_pkg;

   localparam int unsigned UART_DATA_W      = 8;
   localparam int unsigned UART_FIFO_ADDR_W = 4;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Register-array storage for the UART FIFOs.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - asynchronous read data, mem[raddr]
module uart_fifo_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage is intentionally not reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with a sticky
// overrun flag for bytes dropped while full.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   rx_data - received byte, stable from rx_done until the next frame
//   rx_done - receiver frame-complete strobe (rising edge pushes)
//   rd_en   - pop request from the consumer
//   rd_data - head entry, 0 while empty
//   empty   - no entries stored
//   full    - all 2**ADDR_W entries stored
//   count   - number of stored entries
//   overrun - sticky: a byte was dropped because the FIFO was full
//   ovr_clr - synchronous clear of overrun
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned ADDR_W = UART_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
   input  logic              ovr_clr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              rx_done_d;
   logic              overrun_q;
   logic [DATA_W-1:0] ram_rdata;

   logic push_edge_c;
   logic pop_c;
   logic push_c;
   logic drop_c;

   // A push while full is only accepted if a pop frees the slot in the same cycle.
   always_comb begin
      push_edge_c = rx_done & ~rx_done_d;
      pop_c       = rd_en & ~empty;
      push_c      = push_edge_c & (~full | pop_c);
      drop_c      = push_edge_c & full & ~pop_c;
   end

   // Pointers, occupancy, strobe edge detect and sticky overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         rx_done_d <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         rx_done_d <= rx_done;
         if (push_c) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         if (push_c && !pop_c) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count_q <= count_q - CNT_W'(1);
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop_c) begin
            overrun_q <= 1'b1;
         end else if (ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   uart_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (push_c),
      .waddr (wr_ptr),
      .wdata (rx_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign count   = count_q;
   assign overrun = overrun_q;
   assign rd_data = empty ? '0 : ram_rdata;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       rd_en = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] sb [$];
   logic       exp_ovr = 1'b0;

   uart_rx_fifo dut (
      .clk     (clk),
      .reset   (reset),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun),
      .ovr_clr (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      logic [7:0] exp_rd;
      exp_rd = (sb.size() != 0) ? sb[0] : 8'h00;
      chk({tag, ".count"},   32'(count),   32'(sb.size()));
      chk({tag, ".empty"},   32'(empty),   32'(sb.size() == 0));
      chk({tag, ".full"},    32'(full),    32'(sb.size() == DEPTH));
      chk({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
   endtask

   // One-cycle strobe followed by an idle cycle so the next push sees a fresh edge.
   task automatic push_byte(input logic [7:0] b, input string tag);
      rx_data = b;
      rx_done = 1'b1;
      if (sb.size() < DEPTH) sb.push_back(b);
      else exp_ovr = 1'b1;
      step();
      rx_done = 1'b0;
      check_state(tag);
      step();
   endtask

   task automatic pop_byte(input string tag);
      chk({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
      rd_en = 1'b1;
      void'(sb.pop_front());
      step();
      rd_en = 1'b0;
   endtask

   // Push and pop in the same cycle; the model pops first, then pushes.
   task automatic push_pop(input logic [7:0] b, input string tag);
      if (sb.size() != 0) begin
         chk({tag, ".head"}, 32'(rd_data), 32'(sb[0]));
         void'(sb.pop_front());
      end
      sb.push_back(b);
      rx_data = b;
      rx_done = 1'b1;
      rd_en   = 1'b1;
      step();
      rx_done = 1'b0;
      rd_en   = 1'b0;
      check_state(tag);
      step();
   endtask

   task automatic drain(input string tag);
      while (sb.size() != 0) pop_byte(tag);
      check_state({tag, ".drained"});
   endtask

   initial begin
      // Reset
      repeat (3) step();
      check_state("in_reset");
      reset = 1'b1;
      step();
      check_state("after_reset");

      // Single byte, no extra latency
      push_byte(8'hA5, "single");
      pop_byte("single");
      check_state("single_pop");

      // Empty read is ignored
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check_state("empty_rd");

      // Held strobe pushes once
      rx_data = 8'h3C;
      rx_done = 1'b1;
      sb.push_back(8'h3C);
      repeat (5) step();
      check_state("held");
      rx_done = 1'b0;
      step();
      push_byte(8'h3C, "held_again");
      drain("held");

      // Fill, partial drain, refill across pointer wrap
      for (int i = 0; i < 16; i++) push_byte(8'(i), "fill");
      for (int i = 0; i < 4; i++) pop_byte("pop4");
      for (int i = 16; i < 20; i++) push_byte(8'(i), "wrap");
      check_state("wrap_full");
      drain("wrap");

      // Overrun
      for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), "ofill");
      push_byte(8'hEE, "drop");
      rx_data = 8'hEE;
      rx_done = 1'b1;
      ovr_clr = 1'b1;
      step();
      rx_done = 1'b0;
      ovr_clr = 1'b0;
      check_state("drop_vs_clr");
      step();
      ovr_clr = 1'b1;
      exp_ovr = 1'b0;
      step();
      ovr_clr = 1'b0;
      check_state("clr");

      // Push and pop together while full
      push_pop(8'h55, "full_pp");
      drain("full_pp");

      // Push and rd_en together while empty
      push_pop(8'h77, "empty_pp");
      drain("empty_pp");

      // Asynchronous reset mid-operation
      push_byte(8'h11, "pre_rst");
      push_byte(8'h22, "pre_rst");
      reset = 1'b0;
      sb.delete();
      #1;
      check_state("async_rst");
      // Strobe high across reset release pushes once
      rx_data = 8'h99;
      rx_done = 1'b1;
      step();
      reset = 1'b1;
      sb.push_back(8'h99);
      step();
      step();
      rx_done = 1'b0;
      check_state("rst_release_push");
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo
